// File: rtl/dragonfang_pkg.sv
// Shared definitions for the vector conversion writeback stage.
// Optional feature macro (used by vector_conversion_writeback): DRAGONFANG_WB_BACK_TO_BACK_EN
package dragonfang_pkg;

    localparam int unsigned DEFAULT_VRF_ADDRESS_WIDTH = 5;
    localparam int unsigned DEFAULT_DATA_WIDTH        = 64;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_LOW  = 2'd1,
        WRITE_HIGH = 2'd2
    } conversion_writeback_state_t;

endpackage

// File: rtl/conversion_result_register.sv
// Capture register for one conversion result: low/high data words, widening flag
// and destination index. Loaded on acceptance, held otherwise.
module conversion_result_register
    import dragonfang_pkg::*;
#(
    parameter int unsigned VRF_ADDRESS_WIDTH = DEFAULT_VRF_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH        = DEFAULT_DATA_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         load,
    input  logic [DATA_WIDTH-1:0]        in_vd,
    input  logic [DATA_WIDTH-1:0]        in_vd_high,
    input  logic                         in_widening,
    input  logic [VRF_ADDRESS_WIDTH-1:0] in_index,
    output logic [DATA_WIDTH-1:0]        vd,
    output logic [DATA_WIDTH-1:0]        vd_high,
    output logic                         widening,
    output logic [VRF_ADDRESS_WIDTH-1:0] index
);

    logic [DATA_WIDTH-1:0]        vd_q, vd_d;
    logic [DATA_WIDTH-1:0]        vd_high_q, vd_high_d;
    logic                         widening_q, widening_d;
    logic [VRF_ADDRESS_WIDTH-1:0] index_q, index_d;

    // Select new result on load, otherwise hold the current one.
    always_comb begin
        vd_d       = vd_q;
        vd_high_d  = vd_high_q;
        widening_d = widening_q;
        index_d    = index_q;
        if (load) begin
            vd_d       = in_vd;
            vd_high_d  = in_vd_high;
            widening_d = in_widening;
            index_d    = in_index;
        end
    end

    // Capture storage with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            vd_q       <= '0;
            vd_high_q  <= '0;
            widening_q <= 1'b0;
            index_q    <= '0;
        end else begin
            vd_q       <= vd_d;
            vd_high_q  <= vd_high_d;
            widening_q <= widening_d;
            index_q    <= index_d;
        end
    end

    assign vd       = vd_q;
    assign vd_high  = vd_high_q;
    assign widening = widening_q;
    assign index    = index_q;

endmodule

// File: rtl/vector_conversion_writeback.sv
// Writeback stage of the vector conversion unit: takes one result over a
// valid/ready handshake and writes it to the VRF over a request/grant port,
// using two beats (index, index+1) for aligned widening results.
// Optional feature macro: DRAGONFANG_WB_BACK_TO_BACK_EN
//   defined   -> a new result may be accepted in the cycle the final beat is granted
//   undefined -> results are accepted only while idle
module vector_conversion_writeback
    import dragonfang_pkg::*;
#(
    parameter int unsigned VRF_ADDRESS_WIDTH = DEFAULT_VRF_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH        = DEFAULT_DATA_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_vd,
    input  logic [DATA_WIDTH-1:0]        in_vd_high,
    input  logic                         in_widening,
    input  logic [VRF_ADDRESS_WIDTH-1:0] in_vd_index,
    output logic                         vrf_we,
    output logic [VRF_ADDRESS_WIDTH-1:0] vrf_address,
    output logic [DATA_WIDTH-1:0]        vrf_data,
    input  logic                         vrf_grant,
    output logic                         done,
    output logic                         misaligned_error,
    output logic [15:0]                  retired_count
);

    conversion_writeback_state_t state_q, state_d;

    logic                         vrf_we_q, vrf_we_d;
    logic [VRF_ADDRESS_WIDTH-1:0] vrf_address_q, vrf_address_d;
    logic [DATA_WIDTH-1:0]        vrf_data_q, vrf_data_d;
    logic                         misaligned_q, misaligned_d;
    logic [15:0]                  retired_count_q, retired_count_d;

    logic [DATA_WIDTH-1:0]        hold_vd;
    logic [DATA_WIDTH-1:0]        hold_vd_high;
    logic                         hold_widening;
    logic [VRF_ADDRESS_WIDTH-1:0] hold_index;

    logic accept;
    logic high_beat_needed;
    logic final_grant;

    conversion_result_register #(
        .VRF_ADDRESS_WIDTH (VRF_ADDRESS_WIDTH),
        .DATA_WIDTH        (DATA_WIDTH)
    ) u_result (
        .clock       (clock),
        .reset       (reset),
        .load        (accept),
        .in_vd       (in_vd),
        .in_vd_high  (in_vd_high),
        .in_widening (in_widening),
        .in_index    (in_vd_index),
        .vd          (hold_vd),
        .vd_high     (hold_vd_high),
        .widening    (hold_widening),
        .index       (hold_index)
    );

    // Detect the grant of the last beat of the held result; an odd-indexed
    // widening result has no high beat, so its low beat is the last one.
    always_comb begin
        final_grant      = 1'b0;
        high_beat_needed = hold_widening & ~hold_index[0];
        case (state_q)
            WRITE_LOW:  final_grant = vrf_grant & ~high_beat_needed;
            WRITE_HIGH: final_grant = vrf_grant;
            default:    final_grant = 1'b0;
        endcase
    end

`ifdef DRAGONFANG_WB_BACK_TO_BACK_EN
    assign in_ready = (state_q == IDLE) | final_grant;
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept = in_valid & in_ready;

    // Next state, next registered VRF request and counter update.
    always_comb begin
        state_d         = state_q;
        vrf_we_d        = vrf_we_q;
        vrf_address_d   = vrf_address_q;
        vrf_data_d      = vrf_data_q;
        misaligned_d    = 1'b0;
        retired_count_d = retired_count_q + (final_grant ? 16'd1 : 16'd0);

        case (state_q)
            WRITE_LOW: begin
                if (vrf_grant) begin
                    if (high_beat_needed) begin
                        state_d       = WRITE_HIGH;
                        vrf_address_d = hold_index + VRF_ADDRESS_WIDTH'(1);
                        vrf_data_d    = hold_vd_high;
                    end else begin
                        state_d  = IDLE;
                        vrf_we_d = 1'b0;
                    end
                end
            end
            WRITE_HIGH: begin
                if (vrf_grant) begin
                    state_d  = IDLE;
                    vrf_we_d = 1'b0;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // Acceptance overrides the above: from IDLE, or on a final grant when
        // back-to-back mode lets in_ready rise in that cycle.
        if (accept) begin
            state_d       = WRITE_LOW;
            vrf_we_d      = 1'b1;
            vrf_address_d = in_vd_index;
            vrf_data_d    = in_vd;
            misaligned_d  = in_widening & in_vd_index[0];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            vrf_we_q        <= 1'b0;
            vrf_address_q   <= '0;
            vrf_data_q      <= '0;
            misaligned_q    <= 1'b0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            vrf_we_q        <= vrf_we_d;
            vrf_address_q   <= vrf_address_d;
            vrf_data_q      <= vrf_data_d;
            misaligned_q    <= misaligned_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign vrf_we           = vrf_we_q;
    assign vrf_address      = vrf_address_q;
    assign vrf_data         = vrf_data_q;
    assign done             = final_grant;
    assign misaligned_error = misaligned_q;
    assign retired_count    = retired_count_q;

endmodule

// File: tb/tb_vector_conversion_writeback.sv
// Self-checking bench for vector_conversion_writeback: directed scenarios with
// literal expectations, then randomized traffic against a queue-of-beats model.
module tb_vector_conversion_writeback;

    localparam int AW = 5;
    localparam int DW = 64;
`ifdef DRAGONFANG_WB_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_vd;
    logic [DW-1:0] in_vd_high;
    logic          in_widening;
    logic [AW-1:0] in_vd_index;
    logic          vrf_we;
    logic [AW-1:0] vrf_address;
    logic [DW-1:0] vrf_data;
    logic          vrf_grant;
    logic          done;
    logic          misaligned_error;
    logic [15:0]   retired_count;

    always #5 clock = ~clock;

    vector_conversion_writeback #(
        .VRF_ADDRESS_WIDTH (AW),
        .DATA_WIDTH        (DW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_vd            (in_vd),
        .in_vd_high       (in_vd_high),
        .in_widening      (in_widening),
        .in_vd_index      (in_vd_index),
        .vrf_we           (vrf_we),
        .vrf_address      (vrf_address),
        .vrf_data         (vrf_data),
        .vrf_grant        (vrf_grant),
        .done             (done),
        .misaligned_error (misaligned_error),
        .retired_count    (retired_count)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    // Model: the list of VRF writes still owed for the held result.
    beat_t       exp_q[$];
    int unsigned exp_count = 0;
    bit          exp_mis   = 1'b0;
    int          n_cmp     = 0;
    int          n_fail    = 0;
    int          cycle     = 0;
    int          done_cycles[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic bit exp_ready();
        return (exp_q.size() == 0) || (B2B && exp_q.size() == 1 && vrf_grant);
    endfunction

    // Model update at each clock edge from the inputs seen before it.
    always @(posedge clock) begin : model
        bit    rdy;
        beat_t b;
        cycle++;
        if (reset) begin
            exp_q.delete();
            exp_count = 0;
            exp_mis   = 1'b0;
        end else begin
            rdy     = exp_ready();
            exp_mis = 1'b0;
            if (exp_q.size() != 0 && vrf_grant) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_count = (exp_count + 1) & 32'hFFFF;
            end
            if (in_valid && rdy) begin
                b.addr = in_vd_index;
                b.data = in_vd;
                exp_q.push_back(b);
                if (in_widening && !in_vd_index[0]) begin
                    b.addr = in_vd_index + 5'd1;
                    b.data = in_vd_high;
                    exp_q.push_back(b);
                end
                exp_mis = in_widening & in_vd_index[0];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        check("in_ready", in_ready, exp_ready());
        check("vrf_we", vrf_we, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("vrf_address", vrf_address, exp_q[0].addr);
            check("vrf_data", vrf_data, exp_q[0].data);
        end
        check("done", done, exp_q.size() == 1 && vrf_grant);
        check("misaligned_error", misaligned_error, exp_mis);
        check("retired_count", retired_count, exp_count);
        if (done === 1'b1) done_cycles.push_back(cycle);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int  accepted;
        int  budget;
        bit  acc;

        reset = 1'b1; in_valid = 1'b0; in_vd = '0; in_vd_high = '0;
        in_widening = 1'b0; in_vd_index = '0; vrf_grant = 1'b0;
        tick(); tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_vrf_we", vrf_we, 0);
        check("rst_vrf_address", vrf_address, 0);
        check("rst_vrf_data", vrf_data, 0);
        check("rst_done", done, 0);
        check("rst_misaligned", misaligned_error, 0);
        check("rst_retired", retired_count, 0);
        reset = 1'b0;

        // Narrow result
        in_valid = 1'b1; in_vd = 64'h0123_4567_89AB_CDEF; in_widening = 1'b0;
        in_vd_index = 5'd4; vrf_grant = 1'b1;
        tick(); in_valid = 1'b0;
        check("nar_we", vrf_we, 1);
        check("nar_addr", vrf_address, 4);
        check("nar_data", vrf_data, 64'h0123_4567_89AB_CDEF);
        check("nar_done", done, 1);
        tick();
        check("nar_count", retired_count, 1);
        check("nar_idle_we", vrf_we, 0);

        // Widening result
        in_valid = 1'b1; in_vd = 64'h1; in_vd_high = 64'h2; in_widening = 1'b1; in_vd_index = 5'd6;
        tick(); in_valid = 1'b0;
        check("wid_lo_addr", vrf_address, 6);
        check("wid_lo_data", vrf_data, 1);
        check("wid_lo_done", done, 0);
        tick();
        check("wid_hi_we", vrf_we, 1);
        check("wid_hi_addr", vrf_address, 7);
        check("wid_hi_data", vrf_data, 2);
        check("wid_hi_done", done, 1);
        tick();
        check("wid_count", retired_count, 2);

        // Backpressure: three refused cycles, then grant
        vrf_grant = 1'b0;
        in_valid = 1'b1; in_vd = 64'h55; in_widening = 1'b0; in_vd_index = 5'd9;
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) vrf_grant = 1'b1;
            #1;
            check("bp_we", vrf_we, 1);
            check("bp_addr", vrf_address, 9);
            check("bp_data", vrf_data, 64'h55);
            if (i < 3 || !B2B) check("bp_in_ready", in_ready, 0);
            tick();
        end
        check("bp_count", retired_count, 3);

        // Misaligned widening at index 31
        in_valid = 1'b1; in_vd = 64'hAA; in_vd_high = 64'hBB; in_widening = 1'b1; in_vd_index = 5'd31;
        tick(); in_valid = 1'b0;
        check("mis_pulse", misaligned_error, 1);
        check("mis_addr", vrf_address, 31);
        check("mis_data", vrf_data, 64'hAA);
        check("mis_done", done, 1);
        tick();
        check("mis_no_wrap_we", vrf_we, 0);
        check("mis_pulse_end", misaligned_error, 0);
        check("mis_count", retired_count, 4);

        // Reset during the high beat
        in_valid = 1'b1; in_vd = 64'h10; in_vd_high = 64'h20; in_widening = 1'b1; in_vd_index = 5'd2;
        tick(); in_valid = 1'b0;
        tick();
        check("rmid_hi_addr", vrf_address, 3);
        check("rmid_hi_data", vrf_data, 64'h20);
        reset = 1'b1; vrf_grant = 1'b0;
        tick(); reset = 1'b0;
        check("rmid_we", vrf_we, 0);
        check("rmid_in_ready", in_ready, 1);
        check("rmid_count", retired_count, 0);
        tick();
        check("rmid_no_high", vrf_we, 0);

        // Three narrow results offered back to back
        vrf_grant = 1'b1;
        done_cycles.delete();
        accepted = 0;
        budget   = 0;
        while (accepted < 3 && budget < 20) begin
            in_valid = 1'b1; in_widening = 1'b0;
            in_vd = 64'h100 + 64'(accepted); in_vd_index = 5'(10 + accepted);
            #1;
            acc = in_ready;
            tick();
            if (acc) accepted++;
            budget++;
        end
        in_valid = 1'b0;
        check("b2b_accepted", accepted, 3);
        budget = 0;
        while (retired_count !== 16'd3 && budget < 10) begin
            tick();
            budget++;
        end
        check("b2b_count", retired_count, 3);
        check("b2b_done_pulses", done_cycles.size(), 3);
        if (done_cycles.size() == 3)
            check("b2b_span", done_cycles[2] - done_cycles[0], B2B ? 2 : 4);

        // Randomized traffic
        repeat (3000) begin
            reset       = ($urandom_range(0, 199) == 0);
            in_valid    = $urandom_range(0, 2) != 0;
            in_vd       = {$urandom, $urandom};
            in_vd_high  = {$urandom, $urandom};
            in_widening = $urandom_range(0, 1) == 1;
            in_vd_index = ($urandom_range(0, 7) == 0) ? 5'(30 + $urandom_range(0, 1)) : 5'($urandom);
            vrf_grant   = $urandom_range(0, 3) != 0;
            tick();
        end
        reset = 1'b0; in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
